// File: rtl/aclk_snooze_ctrl.sv
// Alarm-clock ring/snooze controller: rising-edge detection on buttons and alarm match,
// a ring/snooze/wait-for-clear state machine and registered buzzer/status outputs.
module aclk_snooze_ctrl #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic       alarm_match,
    input  logic       alarm_enable,
    input  logic       snooze_button,
    input  logic       stop_button,
    output logic       alarm_sound,
    output logic       snooze_active,
    output logic [1:0] snooze_left,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRing    = 2'd1,
        StSnooze  = 2'd2,
        StWaitClr = 2'd3
    } state_e;

    localparam logic [8:0] RingLast   = 9'(RING_SECS - 1);
    localparam logic [8:0] SnoozeLast = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] MaxSnooze  = 2'(MAX_SNOOZE);

    state_e     state_q, state_d;
    logic [8:0] sec_cnt_q, sec_cnt_d;
    logic       beep_phase_q, beep_phase_d;
    logic [1:0] snooze_left_q, snooze_left_d;
    logic       alarm_sound_q, alarm_sound_d;
    logic       snooze_active_q, snooze_active_d;
    logic       match_q, match_d, snooze_q, snooze_d, stop_q, stop_d;
    logic       match_rise_q, match_rise_d;
    logic       snooze_rise_q, snooze_rise_d;
    logic       stop_rise_q, stop_rise_d;

    always_comb begin
        state_d       = state_q;
        sec_cnt_d     = sec_cnt_q;
        beep_phase_d  = beep_phase_q;
        snooze_left_d = snooze_left_q;

        match_d       = alarm_match;
        snooze_d      = snooze_button;
        stop_d        = stop_button;
        // Edges are registered, so the FSM reacts one cycle after the input rises.
        match_rise_d  = alarm_match & ~match_q;
        snooze_rise_d = snooze_button & ~snooze_q;
        stop_rise_d   = stop_button & ~stop_q;

        unique case (state_q)
            StIdle: begin
                if (match_rise_q) begin
                    state_d       = StRing;
                    snooze_left_d = MaxSnooze;
                    beep_phase_d  = 1'b1;
                end
            end
            StRing: begin
                if (stop_rise_q) begin
                    state_d = StWaitClr;
                end else if (snooze_rise_q && snooze_left_q != 2'd0) begin
                    state_d       = StSnooze;
                    snooze_left_d = snooze_left_q - 2'd1;
                end else if (one_second) begin
                    if (sec_cnt_q == RingLast) begin
                        state_d = StWaitClr;
                    end else begin
                        sec_cnt_d    = sec_cnt_q + 9'd1;
                        beep_phase_d = ~beep_phase_q;
                    end
                end
            end
            StSnooze: begin
                if (stop_rise_q) begin
                    state_d = StWaitClr;
                end else if (one_second) begin
                    if (sec_cnt_q == SnoozeLast) begin
                        state_d      = StRing;
                        beep_phase_d = 1'b1;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 9'd1;
                    end
                end
            end
            StWaitClr: begin
                if (!alarm_match) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!alarm_enable) begin
            state_d = StIdle;
        end

        if (state_d != state_q) begin
            sec_cnt_d = '0;
        end

        alarm_sound_d   = (state_d == StRing) && beep_phase_d;
        snooze_active_d = (state_d == StSnooze);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            sec_cnt_q       <= '0;
            beep_phase_q    <= 1'b0;
            snooze_left_q   <= '0;
            alarm_sound_q   <= 1'b0;
            snooze_active_q <= 1'b0;
            match_q         <= 1'b0;
            snooze_q        <= 1'b0;
            stop_q          <= 1'b0;
            match_rise_q    <= 1'b0;
            snooze_rise_q   <= 1'b0;
            stop_rise_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sec_cnt_q       <= sec_cnt_d;
            beep_phase_q    <= beep_phase_d;
            snooze_left_q   <= snooze_left_d;
            alarm_sound_q   <= alarm_sound_d;
            snooze_active_q <= snooze_active_d;
            match_q         <= match_d;
            snooze_q        <= snooze_d;
            stop_q          <= stop_d;
            match_rise_q    <= match_rise_d;
            snooze_rise_q   <= snooze_rise_d;
            stop_rise_q     <= stop_rise_d;
        end
    end

    assign alarm_sound   = alarm_sound_q;
    assign snooze_active = snooze_active_q;
    assign snooze_left   = snooze_left_q;
    assign ctrl_state    = state_q;

endmodule

// File: doc/aclk_snooze_ctrl.md
ACLK_SNOOZE_CTRL -- requirements
Module: aclk_snooze_ctrl

Interface
REQ-001 SHALL have parameter RING_SECS, default 60: one_second pulses of ringing before auto-stop.
REQ-002 SHALL have parameter SNOOZE_SECS, default 300: one_second pulses of silence per snooze.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event, range 0..3.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port one_second, input, 1: one-cycle pulse from the timing generator.
REQ-007 SHALL have port alarm_match, input, 1: level; current time equals alarm time.
REQ-008 SHALL have port alarm_enable, input, 1: level; alarm armed.
REQ-009 SHALL have port snooze_button, input, 1: debounced level.
REQ-010 SHALL have port stop_button, input, 1: debounced level.
REQ-011 SHALL have port alarm_sound, output, 1: registered buzzer drive.
REQ-012 SHALL have port snooze_active, output, 1: registered; high in SNOOZE.
REQ-013 SHALL have port snooze_left, output, 2: registered; remaining snoozes.
REQ-014 SHALL have port ctrl_state, output, 2: registered; IDLE=0, RING=1, SNOOZE=2, WAIT_CLR=3.

Function
REQ-015 SHALL register alarm_match, snooze_button and stop_button once and act only on their rising edges (input high, registered copy low); one cycle of edge-detect latency.
REQ-016 SHALL keep a 9-bit seconds counter sec_cnt, incremented only on one_second pulses in RING or SNOOZE, cleared on every state entry.
REQ-017 SHALL in IDLE enter RING on an alarm_match rising edge while alarm_enable=1, loading snooze_left=MAX_SNOOZE and beep_phase=1.
REQ-018 SHALL in RING drive alarm_sound=beep_phase, toggling beep_phase on each one_second pulse (1 s on / 1 s off pattern).
REQ-019 SHALL in RING go to WAIT_CLR on stop edge, or when one_second arrives with sec_cnt=RING_SECS-1.
REQ-020 SHALL in RING go to SNOOZE on snooze edge when snooze_left>0, decrementing snooze_left; SHALL ignore snooze edge when snooze_left=0.
REQ-021 SHALL in SNOOZE drive alarm_sound=0, snooze_active=1, and return to RING with beep_phase=1 when one_second arrives with sec_cnt=SNOOZE_SECS-1.
REQ-022 SHALL in SNOOZE go to WAIT_CLR on stop edge; SHALL ignore snooze edges.
REQ-023 SHALL in WAIT_CLR drive alarm_sound=0 and go to IDLE when alarm_match=0.
REQ-024 SHALL go to IDLE from any state within one cycle when alarm_enable=0, with alarm_sound=0; a still-high alarm_match SHALL NOT re-trigger without a new rising edge.
REQ-025 SHALL resolve same-cycle events with priority alarm_enable low > stop edge > snooze edge > timeout.
REQ-026 SHALL hold alarm_sound=0 and snooze_active=0 in IDLE and WAIT_CLR.
REQ-027 SHALL ignore one_second pulses in IDLE and WAIT_CLR.

Reset
REQ-028 SHALL on reset asserted, at any time and mid-ring, force ctrl_state=IDLE, alarm_sound=0, snooze_active=0, snooze_left=0, sec_cnt=0, beep_phase=0, all edge registers=0.
REQ-029 SHALL after reset release treat an alarm_match already high as a rising edge (edge register reset to 0).

Verification (RING_SECS=4, SNOOZE_SECS=3, MAX_SNOOZE=2)
REQ-030 SHALL cover: enable=1, match rises -> RING two cycles later, alarm_sound 1,0,1,0 across 4 seconds, then WAIT_CLR; match drops -> IDLE.
REQ-031 SHALL cover: RING, snooze edge -> SNOOZE, snooze_left=1, sound 0; after 3 one_second pulses -> RING, alarm_sound=1.
REQ-032 SHALL cover: two snoozes used (snooze_left=0), third snooze edge -> stays RING; stop edge -> WAIT_CLR.
REQ-033 SHALL cover: stop and snooze rising in the same cycle in RING -> WAIT_CLR, snooze_left unchanged.
REQ-034 SHALL cover: alarm_enable dropped in SNOOZE -> IDLE next cycle; re-enable with match still high -> stays IDLE.
REQ-035 SHALL cover: reset pulsed mid-RING with alarm_sound=1 -> all outputs 0 immediately, asynchronously, with no clock edge.
